// File: rtl/or1200_fwdctrl_pkg.sv
// Shared operand-mux definitions: select encodings and default datapath widths.
package or1200_fwdctrl_pkg;

  localparam int unsigned OR1200_OPERAND_WIDTH = 32;
  localparam int unsigned OR1200_REGFILE_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    SEL_RF      = 2'd0,
    SEL_IMM     = 2'd1,
    SEL_EX_FORW = 2'd2,
    SEL_WB_FORW = 2'd3
  } sel_t;

endpackage

// File: rtl/or1200_fwdctrl_if.sv
// Pipeline-control and forwarding bus between the ID/EX/WB datapath and the forwarding controller.
interface or1200_fwdctrl_if
  import or1200_fwdctrl_pkg::*;
#(
  parameter int unsigned width = OR1200_OPERAND_WIDTH,
  parameter int unsigned aw    = OR1200_REGFILE_ADDR_WIDTH
);

  logic             id_freeze;
  logic             ex_freeze;
  logic             wb_freeze;
  logic             ex_flushpipe;
  logic [aw-1:0]    id_addra;
  logic [aw-1:0]    id_addrb;
  logic             id_imm;
  logic             id_rfwb;
  logic [aw-1:0]    id_rfaddrw;
  logic             id_load;
  logic [width-1:0] ex_result;
  sel_t             sel_a;
  sel_t             sel_b;
  logic [width-1:0] ex_forw;
  logic [width-1:0] wb_forw;
  logic             load_hazard;
  logic             rf_we;
  logic [aw-1:0]    rf_addrw;
  logic [width-1:0] rf_dataw;

  modport master (
    output id_freeze, ex_freeze, wb_freeze, ex_flushpipe,
    output id_addra, id_addrb, id_imm, id_rfwb, id_rfaddrw, id_load, ex_result,
    input  sel_a, sel_b, ex_forw, wb_forw, load_hazard, rf_we, rf_addrw, rf_dataw
  );

  modport slave (
    input  id_freeze, ex_freeze, wb_freeze, ex_flushpipe,
    input  id_addra, id_addrb, id_imm, id_rfwb, id_rfaddrw, id_load, ex_result,
    output sel_a, sel_b, ex_forw, wb_forw, load_hazard, rf_we, rf_addrw, rf_dataw
  );

endinterface

// File: rtl/or1200_fwdcmp.sv
// Per-operand source compare: picks EX over WB forwarding, immediate overrides both, r0 never hits.
module or1200_fwdcmp
  import or1200_fwdctrl_pkg::*;
#(
  parameter int unsigned aw = OR1200_REGFILE_ADDR_WIDTH
) (
  input  logic [aw-1:0] addr,
  input  logic          use_imm,
  input  logic          ex_rfwb,
  input  logic [aw-1:0] ex_rfaddrw,
  input  logic          wb_rfwb,
  input  logic [aw-1:0] wb_rfaddrw,
  output sel_t          sel_c,
  output logic          ex_hit_c
);

  logic addr_nz;
  logic wb_hit;

  always_comb begin
    addr_nz  = (addr != '0);
    ex_hit_c = ex_rfwb && (ex_rfaddrw == addr) && addr_nz;
    wb_hit   = wb_rfwb && (wb_rfaddrw == addr) && addr_nz;
    sel_c    = SEL_RF;
    if (use_imm)       sel_c = SEL_IMM;
    else if (ex_hit_c) sel_c = SEL_EX_FORW;
    else if (wb_hit)   sel_c = SEL_WB_FORW;
  end

endmodule

// File: rtl/or1200_fwdctrl.sv
// Operand forwarding and load-use hazard control; tracks EX/WB destination registers.
module or1200_fwdctrl
  import or1200_fwdctrl_pkg::*;
#(
  parameter int unsigned width = OR1200_OPERAND_WIDTH,
  parameter int unsigned aw    = OR1200_REGFILE_ADDR_WIDTH
) (
  input logic              clk,
  input logic              rst,
  or1200_fwdctrl_if.slave  bus
);

  logic             ex_rfwb_q, ex_rfwb_d;
  logic             ex_load_q, ex_load_d;
  logic [aw-1:0]    ex_rfaddrw_q, ex_rfaddrw_d;
  logic             wb_rfwb_q, wb_rfwb_d;
  logic [aw-1:0]    wb_rfaddrw_q, wb_rfaddrw_d;
  logic [width-1:0] wb_forw_q, wb_forw_d;
  logic             ex_hit_a, ex_hit_b;
  sel_t             sel_a_c, sel_b_c;

  // Stage advance: a frozen ID with a moving EX (or a flush) inserts a bubble.
  always_comb begin
    ex_rfwb_d    = ex_rfwb_q;
    ex_load_d    = ex_load_q;
    ex_rfaddrw_d = ex_rfaddrw_q;
    wb_rfwb_d    = wb_rfwb_q;
    wb_rfaddrw_d = wb_rfaddrw_q;
    wb_forw_d    = wb_forw_q;
    if (!bus.ex_freeze) begin
      if (bus.id_freeze || bus.ex_flushpipe) begin
        ex_rfwb_d = 1'b0;
        ex_load_d = 1'b0;
      end else begin
        ex_rfwb_d    = bus.id_rfwb;
        ex_load_d    = bus.id_load;
        ex_rfaddrw_d = bus.id_rfaddrw;
      end
    end
    if (!bus.wb_freeze) begin
      if (bus.ex_freeze) begin
        wb_rfwb_d = 1'b0;
      end else begin
        wb_rfwb_d    = ex_rfwb_q;
        wb_rfaddrw_d = ex_rfaddrw_q;
        wb_forw_d    = bus.ex_result;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rfwb_q    <= 1'b0;
      ex_load_q    <= 1'b0;
      ex_rfaddrw_q <= '0;
      wb_rfwb_q    <= 1'b0;
      wb_rfaddrw_q <= '0;
      wb_forw_q    <= '0;
    end else begin
      ex_rfwb_q    <= ex_rfwb_d;
      ex_load_q    <= ex_load_d;
      ex_rfaddrw_q <= ex_rfaddrw_d;
      wb_rfwb_q    <= wb_rfwb_d;
      wb_rfaddrw_q <= wb_rfaddrw_d;
      wb_forw_q    <= wb_forw_d;
    end
  end

  or1200_fwdcmp #(.aw(aw)) u_cmp_a (
    .addr       (bus.id_addra),
    .use_imm    (1'b0),
    .ex_rfwb    (ex_rfwb_q),
    .ex_rfaddrw (ex_rfaddrw_q),
    .wb_rfwb    (wb_rfwb_q),
    .wb_rfaddrw (wb_rfaddrw_q),
    .sel_c      (sel_a_c),
    .ex_hit_c   (ex_hit_a)
  );

  or1200_fwdcmp #(.aw(aw)) u_cmp_b (
    .addr       (bus.id_addrb),
    .use_imm    (bus.id_imm),
    .ex_rfwb    (ex_rfwb_q),
    .ex_rfaddrw (ex_rfaddrw_q),
    .wb_rfwb    (wb_rfwb_q),
    .wb_rfaddrw (wb_rfaddrw_q),
    .sel_c      (sel_b_c),
    .ex_hit_c   (ex_hit_b)
  );

  // Operand selects and the hazard must resolve in the same cycle the ID instruction is decoded.
  always_comb begin
    bus.sel_a       = sel_a_c;
    bus.sel_b       = sel_b_c;
    bus.ex_forw     = bus.ex_result;
    bus.wb_forw     = wb_forw_q;
    bus.load_hazard = ex_load_q && ex_rfwb_q && (ex_hit_a || (ex_hit_b && !bus.id_imm));
    bus.rf_we       = wb_rfwb_q && !bus.wb_freeze && (wb_rfaddrw_q != '0);
    bus.rf_addrw    = wb_rfaddrw_q;
    bus.rf_dataw    = wb_forw_q;
  end

endmodule
